// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester-side bundle of the shared UART TX scheduler.
// master = requesters (drive req/data), slave = scheduler (drives gnt/status).
interface uart_tx_sched_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   gnt;
    logic [1:0]        active_id;
    logic              busy;
    logic              done;

    modport master (
        output req, data,
        input  gnt, active_id, busy, done
    );

    modport slave (
        input  req, data,
        output gnt, active_id, busy, done
    );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter feeding one 8N1 UART transmitter.
// Ports: CLKIN, RESETN (async, low), bus (slave: req/data in, gnt/active_id/busy/done out), tx.
module uart_tx_sched #(
    parameter int NREQ     = 2,
    parameter int BAUD_DIV = 414
) (
    input  logic           CLKIN,
    input  logic           RESETN,
    uart_tx_sched_if.slave bus,
    output logic           tx
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [7:0]      byte_sel;
    logic [1:0]      ptr;
    logic [1:0]      ptr_nxt;
    logic [1:0]      win;
    logic [1:0]      active_id_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] gnt_nxt;
    logic            done_q;
    logic            found;
    logic            wrap;
    logic            arb_edge;
    logic            grant;
    logic            busy;

    assign wrap     = (cnt == CW'(BAUD_DIV - 1));
    // req is only looked at in IDLE or on the last cycle of the stop bit.
    assign arb_edge = (state == IDLE) || ((state == STOP) && wrap);
    assign grant    = arb_edge && found;

    // Rotating search: priority k=0 is ptr, then ptr+1, ... modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && bus.req[i] &&
                    ((int'(ptr) + k) % NREQ) == i) begin
                    found = 1'b1;
                    win   = 2'(i);
                end
            end
        end
        ptr_nxt = (int'(win) == NREQ - 1) ? 2'd0 : win + 2'd1;
    end

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = START;
            START:   if (wrap) state_nxt = DATA;
            DATA:    if (wrap && bit_idx == 3'd7) state_nxt = STOP;
            STOP:    if (wrap) state_nxt = found ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx       = 1'b1;
        busy     = (state != IDLE);
        gnt_nxt  = '0;
        byte_sel = '0;
        unique case (state)
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
            default: tx = 1'b1;
        endcase
        for (int i = 0; i < NREQ; i++) begin
            if (grant && win == 2'(i)) begin
                gnt_nxt[i] = 1'b1;
                byte_sel   = bus.data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            ptr         <= '0;
            active_id_q <= '0;
            gnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            gnt_q  <= gnt_nxt;
            done_q <= (state == STOP) && wrap;
            if (grant) begin
                shreg       <= byte_sel;
                active_id_q <= win;
                ptr         <= ptr_nxt;
                cnt         <= '0;
                bit_idx     <= '0;
            end else if (state != IDLE) begin
                if (wrap) begin
                    cnt <= '0;
                    if (state == DATA) begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.active_id = active_id_q;
    assign bus.busy      = busy;
    assign bus.done      = done_q;
endmodule
